// File: rtl/red_pitaya_pfd_pkg.sv
// Shared quadrant encoding and step codes for the phase-frequency detector counter.
package red_pitaya_pfd_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t QUAD_0 = 2'd0;
  localparam quad_t QUAD_1 = 2'd1;
  localparam quad_t QUAD_2 = 2'd2;
  localparam quad_t QUAD_3 = 2'd3;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_SKIP = 2'd3
  } step_e;

  // Gray-style mapping of the comparator pair onto a rotating quadrant index.
  function automatic quad_t quad_encode(input logic i, input logic q);
    case ({i, q})
      2'b00:   return QUAD_0;
      2'b10:   return QUAD_1;
      2'b11:   return QUAD_2;
      default: return QUAD_3;
    endcase
  endfunction

  function automatic step_e step_decode(input quad_t cand, input quad_t quad);
    quad_t diff;
    diff = cand - quad;
    case (diff)
      2'd1:    return STEP_UP;
      2'd3:    return STEP_DN;
      2'd2:    return STEP_SKIP;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/red_pitaya_pfd_quad_filter.sv
// Synchronises the comparator pair and accepts a quadrant only after it has
// been stable for FILT+1 cycles; accept_o is high in the cycle it is taken.
module red_pitaya_pfd_quad_filter
  import red_pitaya_pfd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_i,
  input  logic       q_i,
  output logic [1:0] cand_o,
  output logic [1:0] quad_o,
  output logic       accept_o
);

  localparam logic [8:0] RUN_FULL = 9'(FILT + 1);

  logic [SYNC_STAGES-1:0] i_sync_reg, q_sync_reg;
  logic [SYNC_STAGES-1:0] i_sync_next, q_sync_next;
  logic [1:0]             cand, cand_reg, quad_reg, quad_next;
  logic [8:0]             run_reg, run_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign i_sync_next[gi] = i_i;
        assign q_sync_next[gi] = q_i;
      end else begin : g_tail
        assign i_sync_next[gi] = i_sync_reg[gi-1];
        assign q_sync_next[gi] = q_sync_reg[gi-1];
      end
    end
  endgenerate

  assign cand = quad_encode(i_sync_reg[SYNC_STAGES-1], q_sync_reg[SYNC_STAGES-1]);

  // run_next counts consecutive cycles, including this one, that cand has held.
  always_comb begin
    run_next = 9'd1;
    if (cand == cand_reg) begin
      run_next = (run_reg == RUN_FULL) ? run_reg : run_reg + 9'd1;
    end
  end

  assign accept_o  = (run_next == RUN_FULL) && (cand != quad_reg);
  assign quad_next = accept_o ? cand : quad_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_sync_reg <= '0;
      q_sync_reg <= '0;
      cand_reg   <= QUAD_0;
      run_reg    <= 9'd0;
      quad_reg   <= QUAD_0;
    end else begin
      i_sync_reg <= i_sync_next;
      q_sync_reg <= q_sync_next;
      cand_reg   <= cand;
      run_reg    <= run_next;
      quad_reg   <= quad_next;
    end
  end

  assign cand_o = cand;
  assign quad_o = quad_reg;

endmodule

// File: rtl/red_pitaya_pfd_counter.sv
// Quadrant phase-frequency detector: integrates +/-1 quadrant steps into a
// saturating or wrapping accumulator and counts illegal two-quadrant jumps.
module red_pitaya_pfd_counter
  import red_pitaya_pfd_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int ISR         = 0,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 0,
  parameter int WRAP        = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_i,
  input  logic             q_i,
  input  logic             clear_i,
  input  logic             hold_i,
  output logic [1:0]       quad_o,
  output logic [WIDTH-1:0] integral_o,
  output logic             sat_o,
  output logic             skip_o,
  output logic [7:0]       skip_cnt_o
);

  localparam int            AW      = WIDTH + ISR;
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW-1:0] ACC_ONE = AW'(1);

  logic [1:0]    cand, quad;
  logic          accept;
  step_e         step;
  logic [AW-1:0] acc_reg, acc_next;
  logic          sat_reg, sat_next;
  logic          skip_reg, skip_next;
  logic [7:0]    skip_cnt_reg, skip_cnt_next;

  red_pitaya_pfd_quad_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT       (FILT)
  ) u_quad_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_i     (i_i),
    .q_i     (q_i),
    .cand_o  (cand),
    .quad_o  (quad),
    .accept_o(accept)
  );

  assign step = accept ? step_decode(cand, quad) : STEP_NONE;

  // Clear outranks hold and any step; a step pushing past a limit is dropped.
  always_comb begin
    acc_next = acc_reg;
    if (clear_i) begin
      acc_next = '0;
    end else if (!hold_i) begin
      if (step == STEP_UP && (WRAP != 0 || acc_reg != ACC_MAX)) begin
        acc_next = acc_reg + ACC_ONE;
      end else if (step == STEP_DN && (WRAP != 0 || acc_reg != ACC_MIN)) begin
        acc_next = acc_reg - ACC_ONE;
      end
    end

    sat_next  = (WRAP == 0) && (acc_next == ACC_MAX || acc_next == ACC_MIN);
    skip_next = (step == STEP_SKIP);

    skip_cnt_next = skip_cnt_reg;
    if (clear_i) begin
      skip_cnt_next = 8'd0;
    end else if (skip_next && skip_cnt_reg != 8'hFF) begin
      skip_cnt_next = skip_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_reg      <= '0;
      sat_reg      <= 1'b0;
      skip_reg     <= 1'b0;
      skip_cnt_reg <= 8'd0;
    end else begin
      acc_reg      <= acc_next;
      sat_reg      <= sat_next;
      skip_reg     <= skip_next;
      skip_cnt_reg <= skip_cnt_next;
    end
  end

  assign quad_o     = quad;
  assign integral_o = acc_reg[AW-1:ISR];
  assign sat_o      = sat_reg;
  assign skip_o     = skip_reg;
  assign skip_cnt_o = skip_cnt_reg;

endmodule

// File: tb/tb_red_pitaya_pfd_counter.sv
// Bench for red_pitaya_pfd_counter: four parameterisations share one stimulus
// stream and are compared every cycle against a pin-history reference model.
module tb_red_pitaya_pfd_counter;

  localparam int ND = 4;
  localparam int S  = 2;
  localparam int P_WIDTH [ND] = '{14, 4, 4, 14};
  localparam int P_WRAP  [ND] = '{0, 0, 1, 0};
  localparam int P_FILT  [ND] = '{0, 0, 0, 3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i = 1'b0, q = 1'b0, clear = 1'b0, hold = 1'b0;

  logic [1:0]  quad_d [ND];
  logic        sat_d  [ND];
  logic        skip_d [ND];
  logic [7:0]  cnt_d  [ND];
  logic [13:0] int_d  [ND];
  logic [3:0]  int_s, int_w;

  assign int_d[1] = {10'd0, int_s};
  assign int_d[2] = {10'd0, int_w};

  always #5 clk = ~clk;

  red_pitaya_pfd_counter dut0 (
    .clk_i(clk), .rst_i(rst), .i_i(i), .q_i(q), .clear_i(clear), .hold_i(hold),
    .quad_o(quad_d[0]), .integral_o(int_d[0]), .sat_o(sat_d[0]), .skip_o(skip_d[0]),
    .skip_cnt_o(cnt_d[0]));

  red_pitaya_pfd_counter #(.WIDTH(4), .WRAP(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .i_i(i), .q_i(q), .clear_i(clear), .hold_i(hold),
    .quad_o(quad_d[1]), .integral_o(int_s), .sat_o(sat_d[1]), .skip_o(skip_d[1]),
    .skip_cnt_o(cnt_d[1]));

  red_pitaya_pfd_counter #(.WIDTH(4), .WRAP(1)) dut_w (
    .clk_i(clk), .rst_i(rst), .i_i(i), .q_i(q), .clear_i(clear), .hold_i(hold),
    .quad_o(quad_d[2]), .integral_o(int_w), .sat_o(sat_d[2]), .skip_o(skip_d[2]),
    .skip_cnt_o(cnt_d[2]));

  red_pitaya_pfd_counter #(.FILT(3)) dut_f (
    .clk_i(clk), .rst_i(rst), .i_i(i), .q_i(q), .clear_i(clear), .hold_i(hold),
    .quad_o(quad_d[3]), .integral_o(int_d[3]), .sat_o(sat_d[3]), .skip_o(skip_d[3]),
    .skip_cnt_o(cnt_d[3]));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pin quadrant seen at every edge since reset.
  int     hist [$];
  int     m_quad [ND];
  longint m_acc  [ND];
  int     m_cnt  [ND];
  bit     m_skip [ND];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int quad_of(input logic pi, input logic pq);
    case ({pi, pq})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int cand_at(input int idx);
    if (idx < 0) return 0;
    return hist[idx];
  endfunction

  function automatic longint acc_hi(input int d);
    return (longint'(1) << (P_WIDTH[d] - 1)) - 1;
  endfunction

  task automatic model_edge(input int d);
    int     n, c, diff;
    bit     stable;
    longint hi, lo;
    n = hist.size() - 1;
    c = cand_at(n - S);
    stable = 1'b1;
    for (int k = 1; k <= P_FILT[d]; k++)
      if (cand_at(n - S - k) != c) stable = 1'b0;
    diff = (stable && c != m_quad[d]) ? ((c - m_quad[d]) & 3) : 0;
    if (diff != 0) m_quad[d] = c;
    m_skip[d] = (diff == 2);
    hi = acc_hi(d);
    lo = -hi - 1;
    if (clear) begin
      m_acc[d] = 0;
      m_cnt[d] = 0;
    end else begin
      if (!hold && diff == 1) m_acc[d] = m_acc[d] + 1;
      if (!hold && diff == 3) m_acc[d] = m_acc[d] - 1;
      if (m_acc[d] > hi) m_acc[d] = (P_WRAP[d] != 0) ? lo : hi;
      if (m_acc[d] < lo) m_acc[d] = (P_WRAP[d] != 0) ? hi : lo;
      if (diff == 2 && m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
    end
  endtask

  task automatic cmp_dut(input int d);
    longint hi, lo, mask;
    bit     sat;
    hi   = acc_hi(d);
    lo   = -hi - 1;
    mask = (longint'(1) << P_WIDTH[d]) - 1;
    sat  = (P_WRAP[d] == 0) && (m_acc[d] == hi || m_acc[d] == lo);
    check($sformatf("d%0d_quad", d), 64'(quad_d[d]), 64'(m_quad[d]));
    check($sformatf("d%0d_int", d), 64'(int_d[d]), 64'(m_acc[d] & mask));
    check($sformatf("d%0d_sat", d), 64'(sat_d[d]), 64'(sat));
    check($sformatf("d%0d_skip", d), 64'(skip_d[d]), 64'(m_skip[d]));
    check($sformatf("d%0d_cnt", d), 64'(cnt_d[d]), 64'(m_cnt[d]));
  endtask

  task automatic tick();
    hist.push_back(quad_of(i, q));
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) model_edge(d);
    for (int d = 0; d < ND; d++) cmp_dut(d);
  endtask

  // Outputs must drop the instant reset rises, before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    hist.delete();
    for (int d = 0; d < ND; d++) begin
      m_quad[d] = 0; m_acc[d] = 0; m_cnt[d] = 0; m_skip[d] = 1'b0;
      cmp_dut(d);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_pins(input logic [1:0] iq);
    {i, q} = iq;
  endtask

  typedef struct {
    logic [1:0]  iq;
    logic        clr;
    logic        hld;
    logic [13:0] exp_int;
    logic [1:0]  exp_quad;
    logic [7:0]  exp_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  logic [1:0] fwd [4];

  initial begin
    fwd = '{2'b00, 2'b10, 2'b11, 2'b01};
    vecs[0]  = '{2'b10, 1'b0, 1'b0, 14'h0001, 2'd1, 8'd0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 14'h0002, 2'd2, 8'd0};
    vecs[2]  = '{2'b01, 1'b0, 1'b0, 14'h0003, 2'd3, 8'd0};
    vecs[3]  = '{2'b00, 1'b0, 1'b0, 14'h0004, 2'd0, 8'd0};
    vecs[4]  = '{2'b01, 1'b0, 1'b0, 14'h0003, 2'd3, 8'd0};
    vecs[5]  = '{2'b11, 1'b0, 1'b0, 14'h0002, 2'd2, 8'd0};
    vecs[6]  = '{2'b10, 1'b0, 1'b0, 14'h0001, 2'd1, 8'd0};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 14'h0000, 2'd0, 8'd0};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, 14'h3FFF, 2'd3, 8'd0};
    vecs[9]  = '{2'b11, 1'b0, 1'b0, 14'h3FFE, 2'd2, 8'd0};
    vecs[10] = '{2'b10, 1'b0, 1'b0, 14'h3FFD, 2'd1, 8'd0};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 14'h3FFC, 2'd0, 8'd0};
    vecs[12] = '{2'b11, 1'b0, 1'b0, 14'h3FFC, 2'd2, 8'd1};
    vecs[13] = '{2'b01, 1'b0, 1'b1, 14'h3FFC, 2'd3, 8'd1};
    vecs[14] = '{2'b01, 1'b0, 1'b0, 14'h3FFC, 2'd3, 8'd1};
    vecs[15] = '{2'b00, 1'b0, 1'b0, 14'h3FFD, 2'd0, 8'd1};
    vecs[16] = '{2'b00, 1'b1, 1'b0, 14'h0000, 2'd0, 8'd0};
    vecs[17] = '{2'b10, 1'b0, 1'b0, 14'h0001, 2'd1, 8'd0};

    #2;
    do_reset();

    // Table: each vector held 10 cycles, then the default instance is checked.
    for (int v = 0; v < NV; v++) begin
      set_pins(vecs[v].iq);
      clear = vecs[v].clr;
      hold  = vecs[v].hld;
      repeat (10) tick();
      check($sformatf("vec%0d_int", v), 64'(int_d[0]), 64'(vecs[v].exp_int));
      check($sformatf("vec%0d_quad", v), 64'(quad_d[0]), 64'(vecs[v].exp_quad));
      check($sformatf("vec%0d_cnt", v), 64'(cnt_d[0]), 64'(vecs[v].exp_cnt));
      $display("vec %0d iq=%b clr=%b hold=%b -> int=%h quad=%0d cnt=%0d",
               v, vecs[v].iq, vecs[v].clr, vecs[v].hld, int_d[0], quad_d[0], cnt_d[0]);
    end
    clear = 1'b0;
    hold  = 1'b0;

    // Glitch rejection and latency for the filtered and unfiltered instances.
    do_reset();
    set_pins(2'b10);
    repeat (2) tick();
    set_pins(2'b00);
    repeat (8) tick();
    check("glitch_f_int", 64'(int_d[3]), 64'd0);
    check("glitch_f_quad", 64'(quad_d[3]), 64'd0);
    set_pins(2'b10);
    repeat (2) tick();
    check("lat0_before", 64'(int_d[0]), 64'd0);
    tick();
    check("lat0_at3", 64'(int_d[0]), 64'd1);
    repeat (2) tick();
    check("latf_at5", 64'(int_d[3]), 64'd0);
    tick();
    check("latf_at6", 64'(int_d[3]), 64'd1);
    $display("latency: dut0 int=%0d at 3, dut_f int=%0d at 6", int_d[0], int_d[3]);

    // Saturation versus wrap on the 4-bit instances.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      set_pins(fwd[k % 4]);
      repeat (4) tick();
      if (k == 7) begin
        check("sat_s7_int", 64'(int_s), 64'd7);
        check("sat_s7_sat", 64'(sat_d[1]), 64'd1);
        check("wrap_w7_int", 64'(int_w), 64'd7);
      end
      if (k == 8) check("wrap_w8_int", 64'(int_w), 64'h8);
      if (k == 9) check("wrap_w9_int", 64'(int_w), 64'h9);
      $display("fwd step %0d: sat_int=%0d sat=%b wrap_int=%h", k, int_s, sat_d[1], int_w);
    end
    check("sat_s10_int", 64'(int_s), 64'd7);
    check("sat_s10_sat", 64'(sat_d[1]), 64'd1);
    set_pins(fwd[1]);
    repeat (4) tick();
    check("sat_back_int", 64'(int_s), 64'd6);
    check("sat_back_sat", 64'(sat_d[1]), 64'd0);
    check("wrap_back_int", 64'(int_w), 64'h9);
    check("wrap_sat_tied", 64'(sat_d[2]), 64'd0);

    // Skip pulse, skip counter saturation, skip coincident with clear.
    do_reset();
    set_pins(2'b11);
    repeat (2) tick();
    check("skip_early", 64'(skip_d[0]), 64'd0);
    tick();
    check("skip_pulse", 64'(skip_d[0]), 64'd1);
    tick();
    check("skip_single", 64'(skip_d[0]), 64'd0);
    check("skip_cnt1", 64'(cnt_d[0]), 64'd1);
    check("skip_int", 64'(int_d[0]), 64'd0);
    check("skip_quad", 64'(quad_d[0]), 64'd2);
    for (int j = 0; j < 299; j++) begin
      set_pins((j % 2 == 0) ? 2'b00 : 2'b11);
      repeat (3) tick();
    end
    check("skip_cnt_sat", 64'(cnt_d[0]), 64'd255);
    $display("300 skips: skip_cnt=%0d", cnt_d[0]);
    set_pins(2'b11);
    repeat (2) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("skipclr_pulse", 64'(skip_d[0]), 64'd1);
    check("skipclr_cnt", 64'(cnt_d[0]), 64'd0);

    // Clear racing a forward step, then reset with a pending quadrant.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      set_pins(fwd[k % 4]);
      repeat (4) tick();
    end
    check("clr_pre_int", 64'(int_d[0]), 64'd5);
    set_pins(fwd[2]);
    repeat (2) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_step_int", 64'(int_d[0]), 64'd0);
    check("clr_step_quad", 64'(quad_d[0]), 64'd2);
    set_pins(fwd[3]);
    repeat (4) tick();
    set_pins(fwd[0]);
    repeat (4) tick();
    check("prerst_int", 64'(int_d[0]), 64'd2);
    set_pins(fwd[1]);
    tick();
    do_reset();
    $display("reset mid-sequence: int=%0d quad=%0d", int_d[0], quad_d[0]);
    set_pins(2'b00);
    repeat (6) tick();

    // Randomised segments against the model.
    for (int s = 0; s < 250; s++) begin
      int len;
      if ($urandom_range(0, 99) == 0) do_reset();
      set_pins(2'($urandom_range(0, 3)));
      clear = ($urandom_range(0, 19) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      len   = $urandom_range(1, 10);
      repeat (len) tick();
      $display("seg %0d iq=%b len=%0d clr=%b hold=%b -> int0=%h sat_int=%h wrap_int=%h filt_int=%h",
               s, {i, q}, len, clear, hold, int_d[0], int_s, int_w, int_d[3]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
